// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with valid/ready bit input and symbol output.
// Define CONV_ENC_TAIL_EN to append two zero tail bits that terminate the trellis in 00.
module conv_encoder #(
  parameter int         FRAME_LEN = 16,
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_bit_valid,
  input  logic       i_bit,
  output logic       o_bit_ready,
  output logic       o_sym_valid,
  output logic [1:0] o_sym,
  input  logic       i_sym_ready,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int             CW   = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0]  LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
`ifdef CONV_ENC_TAIL_EN
    TAIL,
`endif
    DRAIN
  } state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_sreg;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sym;
  logic          r_sym_valid;
  logic          r_frame_done;
`ifdef CONV_ENC_TAIL_EN
  logic          r_tail_cnt;
`endif

  logic       w_slot_free;
  logic       w_accept;
  logic       w_load;
  logic       w_in;
  logic       w_clear;
  logic       w_done;
  logic [1:0] w_sym;

  assign w_slot_free = !r_sym_valid || i_sym_ready;

  always_comb begin
    w_next      = r_state;
    o_bit_ready = 1'b0;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_in        = 1'b0;
    w_clear     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next  = DATA;
          w_clear = 1'b1;
        end
      end
      DATA: begin
        o_bit_ready = w_slot_free;
        if (i_bit_valid && w_slot_free) begin
          w_accept = 1'b1;
          w_load   = 1'b1;
          w_in     = i_bit;
          if (r_cnt == LAST) begin
`ifdef CONV_ENC_TAIL_EN
            w_next = TAIL;
`else
            w_next = DRAIN;
`endif
          end
        end
      end
`ifdef CONV_ENC_TAIL_EN
      // Zero bits are injected whenever the output slot frees up, so no bubbles after data.
      TAIL: begin
        if (w_slot_free) begin
          w_load = 1'b1;
          if (r_tail_cnt) w_next = DRAIN;
        end
      end
`endif
      DRAIN: begin
        if (r_sym_valid && i_sym_ready) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_sym = {^(G0 & {w_in, r_sreg}), ^(G1 & {w_in, r_sreg})};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sreg       <= '0;
      r_cnt        <= '0;
      r_sym        <= '0;
      r_sym_valid  <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      r_tail_cnt   <= 1'b0;
`endif
    end else begin
      r_frame_done <= w_done;
      if (w_clear) begin
        r_sreg     <= '0;
        r_cnt      <= '0;
`ifdef CONV_ENC_TAIL_EN
        r_tail_cnt <= 1'b0;
`endif
      end else if (w_load) begin
        r_sreg <= {w_in, r_sreg[1]};
        if (w_accept) r_cnt <= r_cnt + 1'b1;
`ifdef CONV_ENC_TAIL_EN
        else          r_tail_cnt <= 1'b1;
`endif
      end
      if (w_load) begin
        r_sym       <= w_sym;
        r_sym_valid <= 1'b1;
      end else if (i_sym_ready) begin
        r_sym_valid <= 1'b0;
      end
    end
  end

  assign o_sym_valid  = r_sym_valid;
  assign o_sym        = r_sym;
  assign o_busy       = (r_state != IDLE);
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed vectors plus randomized handshakes
// compared against a polynomial-level reference of the rate-1/2 K=3 code.
module tb_conv_encoder;

  localparam int         FL = 4;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;
`ifdef CONV_ENC_TAIL_EN
  localparam int TN = 2;
`else
  localparam int TN = 0;
`endif
  localparam int NSYM = FL + TN;

  logic       i_clk, i_rst_n, i_start, i_bit_valid, i_bit, i_sym_ready;
  logic       o_bit_ready, o_sym_valid, o_busy, o_frame_done;
  logic [1:0] o_sym;

  int checks = 0;
  int passed = 0;

  conv_encoder #(.FRAME_LEN(FL), .G0(G0), .G1(G1)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_bit_valid  (i_bit_valid),
    .i_bit        (i_bit),
    .o_bit_ready  (o_bit_ready),
    .o_sym_valid  (o_sym_valid),
    .o_sym        (o_sym),
    .i_sym_ready  (i_sym_ready),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Information sequence with implicit zeros before the frame and as tail after it.
  function automatic logic ubit(input logic [FL-1:0] b, input int k);
    if (k < 0 || k >= FL) return 1'b0;
    return b[k];
  endfunction

  function automatic logic [1:0] ref_sym(input logic [FL-1:0] b, input int k);
    logic p0, p1;
    p0 = (G0[2] & ubit(b, k)) ^ (G0[1] & ubit(b, k - 1)) ^ (G0[0] & ubit(b, k - 2));
    p1 = (G1[2] & ubit(b, k)) ^ (G1[1] & ubit(b, k - 1)) ^ (G1[0] & ubit(b, k - 2));
    return {p0, p1};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_frame(input logic [FL-1:0] bits, input int vprob, input int rprob,
                           input int hold, input bit pre_started, input bit chain,
                           input string name);
    logic [1:0] got[$];
    logic [1:0] prev_sym;
    bit         prev_stall;
    bit         done;
    bit         exp_ready;
    int         idx;
    if (!pre_started) begin
      i_start = 1'b1;
      i_bit_valid = 1'b0;
      step();
      i_start = 1'b0;
    end
    checks++;
    if (o_busy !== 1'b1) $display("FAIL %s busy_after_start: got %b expected 1", name, o_busy);
    else passed++;
    done = 0; idx = 0; prev_stall = 0; prev_sym = '0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      i_start = o_busy && ($urandom_range(3) == 0);
      if (idx < FL) begin
        i_bit_valid = (vprob < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < vprob);
        i_bit = bits[idx];
      end else begin
        i_bit_valid = $urandom_range(1);
        i_bit = $urandom_range(1);
      end
      if (hold > 0 && o_sym_valid) begin
        i_sym_ready = 1'b0;
        hold--;
      end else begin
        i_sym_ready = ($urandom_range(99) < rprob);
      end
      #1;
      if (o_frame_done === 1'b1) begin
        checks++;
        if ({o_busy, o_sym_valid} !== 2'b00 || idx != FL)
          $display("FAIL %s done_state: got busy=%b valid=%b bits=%0d expected 0 0 %0d",
                   name, o_busy, o_sym_valid, idx, FL);
        else passed++;
        done = 1;
        i_start = chain;
        i_bit_valid = 1'b0;
        if (chain) begin
          step();
          i_start = 1'b0;
        end
      end else begin
        if (prev_stall) begin
          checks++;
          if ({o_sym_valid, o_sym} !== {1'b1, prev_sym})
            $display("FAIL %s hold_stable: got %b%b expected 1%b", name, o_sym_valid, o_sym, prev_sym);
          else passed++;
        end
        exp_ready = (idx < FL) && (!o_sym_valid || i_sym_ready);
        checks++;
        if (o_bit_ready !== exp_ready)
          $display("FAIL %s bit_ready cyc%0d: got %b expected %b", name, cyc, o_bit_ready, exp_ready);
        else passed++;
        if (i_bit_valid && o_bit_ready) idx++;
        if (o_sym_valid && i_sym_ready) got.push_back(o_sym);
        prev_stall = o_sym_valid && !i_sym_ready;
        prev_sym = o_sym;
        step();
      end
    end
    checks++;
    if (!done) $display("FAIL %s timeout: got no frame_done expected frame_done", name);
    else passed++;
    checks++;
    if (got.size() != NSYM) $display("FAIL %s sym_count: got %0d expected %0d", name, got.size(), NSYM);
    else passed++;
    for (int k = 0; k < got.size() && k < NSYM; k++) begin
      checks++;
      if (got[k] !== ref_sym(bits, k))
        $display("FAIL %s sym[%0d]: got %b expected %b", name, k, got[k], ref_sym(bits, k));
      else passed++;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_start = 1'b0; i_bit_valid = 1'b1; i_bit = 1'b1; i_sym_ready = 1'b1;
    #1;
    checks++;
    if ({o_bit_ready, o_sym_valid, o_sym, o_busy, o_frame_done} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000",
               {o_bit_ready, o_sym_valid, o_sym, o_busy, o_frame_done});
    else passed++;
    step(); step();
    i_rst_n = 1'b1;
    i_bit_valid = 1'b0;
    step();
    checks++;
    if ({o_busy, o_sym_valid} !== 2'b00)
      $display("FAIL reset_idle: got %b expected 00", {o_busy, o_sym_valid});
    else passed++;
  endtask

  task automatic test_vector();
    logic [1:0]    vec [6];
    logic [FL-1:0] bits;
    vec[0] = 2'b11; vec[1] = 2'b10; vec[2] = 2'b00;
    vec[3] = 2'b01; vec[4] = 2'b01; vec[5] = 2'b11;
    bits = 4'b1101;
    i_sym_ready = 1'b1; i_bit_valid = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c <= NSYM + 1; c++) begin
      i_bit_valid = (c < FL);
      i_bit = (c < FL) ? bits[c] : 1'b0;
      #1;
      checks++;
      if (c == 0) begin
        if ({o_busy, o_bit_ready, o_sym_valid} !== 3'b110)
          $display("FAIL vec_first: got %b expected 110", {o_busy, o_bit_ready, o_sym_valid});
        else passed++;
      end else if (c <= NSYM) begin
        if ({o_sym_valid, o_sym, o_frame_done} !== {1'b1, vec[c-1], 1'b0})
          $display("FAIL vec_sym[%0d]: got %b%b done=%b expected 1%b done=0",
                   c - 1, o_sym_valid, o_sym, o_frame_done, vec[c-1]);
        else passed++;
      end else begin
        if ({o_frame_done, o_busy, o_sym_valid} !== 3'b100)
          $display("FAIL vec_done: got %b expected 100", {o_frame_done, o_busy, o_sym_valid});
        else passed++;
      end
      if (c <= NSYM) step();
    end
    i_bit_valid = 1'b0;
    step();
    checks++;
    if (o_frame_done !== 1'b0) $display("FAIL vec_done_width: got %b expected 0", o_frame_done);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    i_sym_ready = 1'b1; i_start = 1'b1; i_bit_valid = 1'b0;
    step();
    i_start = 1'b0;
    i_bit_valid = 1'b1; i_bit = 1'b1;
    step();
    i_bit = 1'b0;
    step();
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_bit_ready, o_sym_valid, o_sym, o_busy, o_frame_done} !== 6'b0)
      $display("FAIL midframe_reset: got %b expected 000000",
               {o_bit_ready, o_sym_valid, o_sym, o_busy, o_frame_done});
    else passed++;
    step();
    i_rst_n = 1'b1;
    step();
    checks++;
    if ({o_busy, o_bit_ready, o_sym_valid} !== 3'b000)
      $display("FAIL after_reset_idle: got %b expected 000", {o_busy, o_bit_ready, o_sym_valid});
    else passed++;
    i_bit_valid = 1'b0;
    run_frame(4'b1101, 100, 100, 0, 1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++)
      run_frame(FL'($urandom), $urandom_range(100, 30), $urandom_range(100, 30), 0,
                1'b0, 1'b0, "random");
  endtask

  task automatic test_back_to_back();
    logic [FL-1:0] a, b;
    a = FL'($urandom);
    b = FL'($urandom);
    run_frame(a, 100, 100, 0, 1'b0, 1'b1, "b2b_first");
    run_frame(b, 100, 100, 0, 1'b1, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_vector();
    run_frame(4'b1101, 100, 100, 3, 1'b0, 1'b0, "backpressure");
    run_frame(4'b1101, -1, 100, 0, 1'b0, 1'b0, "bubbles");
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2, constraint-length-3 convolutional encoder: the transmit-side counterpart of the Viterbi decoder. It accepts a frame of information bits over a valid/ready handshake and emits one 2-bit code symbol per bit. It terminates the trellis with zero tail bits, so the decoder's ACS path metrics start and end in state 00. Symbol bit order matches the decoder's 2-bit branch-metric inputs.

## Interface
Parameters:
- FRAME_LEN, 16: information bits per frame; must be ≥ 1.
- G0, 3'b111: generator for o_sym[1], applied to {current bit, s1, s0}.
- G1, 3'b101: generator for o_sym[0], applied to {current bit, s1, s0}.

Ports:
- i_clk  in  1  single clock; all logic is rising-edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  starts a frame; honoured only in IDLE.
- i_bit_valid  in  1  an information bit is offered.
- i_bit  in  1  the information bit.
- o_bit_ready  out  1  encoder accepts i_bit this cycle.
- o_sym_valid  out  1  o_sym holds a valid code symbol.
- o_sym  out  2  code symbol {G0 parity, G1 parity}.
- i_sym_ready  in  1  downstream consumes o_sym.
- o_busy  out  1  high whenever state ≠ IDLE.
- o_frame_done  out  1  one-cycle pulse at the end of a frame.

## Operation
- The FSM has four states: IDLE, DATA, TAIL and DRAIN.
- IDLE → DATA on i_start. On entry, clear the shift register {s1,s0} to 00 and the bit counter to 0.
- An output slot is free when !o_sym_valid or i_sym_ready.
- In DATA:
  - o_bit_ready = slot free.
  - A bit is accepted when i_bit_valid & o_bit_ready.
  - On accept, register o_sym[1] = ^(G0 & {i_bit,s1,s0}) and o_sym[0] = ^(G1 & {i_bit,s1,s0}), and set o_sym_valid.
  - On accept, shift {s1,s0} ← {i_bit,s1} and increment the counter.
  - The counter is $clog2(FRAME_LEN+1) bits wide.
  - When the FRAME_LEN-th bit is accepted, go to TAIL.
- In TAIL:
  - o_bit_ready = 0.
  - The encoder injects 2 zero bits internally, one per free slot, encoded and shifted exactly like data.
  - After the second tail bit is injected, go to DRAIN.
- In DRAIN: wait until the last symbol handshakes out (o_sym_valid & i_sym_ready).
- The cycle after that handshake: o_frame_done = 1 for one cycle and the FSM is in IDLE.
- Output stability: while o_sym_valid & !i_sym_ready, o_sym and o_sym_valid hold unchanged.
- When a symbol is consumed and no new one is loaded in the same cycle, o_sym_valid drops to 0.
- i_start is ignored outside IDLE.
- i_bit_valid outside DATA is ignored; no bit is consumed.
- Reset (asynchronous, any time, including mid-frame):
  - State → IDLE, {s1,s0} → 00, counter → 0.
  - o_sym_valid = 0, o_sym = 00, o_bit_ready = 0, o_busy = 0, o_frame_done = 0.
  - Any partial frame is discarded.

## Timing
- Latency: a bit accepted in cycle n appears with o_sym_valid = 1 in cycle n+1.
- With i_bit_valid and i_sym_ready held high, throughput is one symbol per cycle.
- Tail symbols follow the last data symbol back-to-back; no bubbles are allowed.
- i_start sampled in IDLE in cycle n gives o_busy = 1 in cycle n+1, and o_bit_ready may be 1 in n+1.
- o_bit_ready depends combinationally on i_sym_ready. There is no combinational path from i_bit_valid to o_bit_ready.
- o_frame_done is registered and one cycle wide.
- An i_start in the same cycle as o_frame_done is accepted.
- Frame length: FRAME_LEN+2 symbols with tail enabled, FRAME_LEN symbols without.

## Configuration
- The only compile-time option is the macro CONV_ENC_TAIL_EN.
- With CONV_ENC_TAIL_EN defined:
  - The TAIL state exists and 2 zero tail symbols are appended per frame.
  - The trellis terminates in state 00.
- Without CONV_ENC_TAIL_EN:
  - TAIL is compiled out; DATA goes directly to DRAIN after the FRAME_LEN-th bit.
  - The trellis is truncated and the final state is not forced.
  - {s1,s0} is still cleared at each i_start.

## Test plan
- Encode vector, FRAME_LEN=4, tail enabled, i_sym_ready=1: bits 1,0,1,1 → symbols 11,10,00,01,01,11 on consecutive cycles, then o_frame_done one cycle after the last symbol.
- Same frame without CONV_ENC_TAIL_EN: → 11,10,00,01 only, then o_frame_done.
- Backpressure: hold i_sym_ready=0 for 3 cycles after the first symbol → o_sym stays 11 and o_bit_ready=0 throughout; the stream completes unchanged after release.
- Bubbles: i_bit_valid toggles 1,0,1,0 → o_sym_valid gaps mirror the input; symbol values are identical to the first test.
- Reset mid-frame: assert i_rst_n=0 after 2 bits → all outputs drop to reset values immediately. A new frame 1,0,1,1 then yields 11,10,00,01,01,11, with no stale state.
- Start handling: i_start pulsed while o_busy=1 → ignored. i_start in the o_frame_done cycle → next frame starts, with o_busy=1 in the following cycle.
